// File: rtl/accumulate_and_dump.sv
// accumulate_and_dump: integrate a signed sample stream over PERIOD-clock
// windows aligned to sync, dumping each window sum with a one-cycle strobe.
// Optional feature macro: ACC_SATURATE_EN (saturating adds + overflow flag).
// Without it, adds wrap modulo 2^OUT_WIDTH and overflow is tied low.
module accumulate_and_dump #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 24,
  parameter int unsigned PERIOD    = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 overflow
);

  localparam int unsigned CTR_WIDTH = $clog2(PERIOD);
  localparam logic [CTR_WIDTH-1:0] CTR_LAST = CTR_WIDTH'(PERIOD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CTR_WIDTH-1:0] ctr;
  logic [CTR_WIDTH-1:0] ctr_nxt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_nxt;
  logic [OUT_WIDTH-1:0] dout_nxt;
  logic                 dout_valid_nxt;

  logic [OUT_WIDTH-1:0] din_ext;
  logic [OUT_WIDTH-1:0] base;
  logic [OUT_WIDTH-1:0] step_sum;
  logic                 win_start;
  logic                 win_last;

  // Sign-extended sample and the running value this step adds onto
  assign din_ext   = OUT_WIDTH'($signed(din));
  assign win_start = (ctr == '0);
  assign win_last  = (ctr == CTR_LAST);
  assign base      = win_start ? '0 : acc;

`ifdef ACC_SATURATE_EN
  localparam logic [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH:0] sum_wide;
  logic               step_ovf;
  logic               ovf_window;
  logic               ovf_window_nxt;
  logic               overflow_nxt;

  // One-bit-wider add; sign bits disagreeing means the step overflowed
  always_comb begin
    sum_wide = {base[OUT_WIDTH-1], base} + {din_ext[OUT_WIDTH-1], din_ext};
    step_ovf = sum_wide[OUT_WIDTH] ^ sum_wide[OUT_WIDTH-1];
    if (!step_ovf) begin
      step_sum = sum_wide[OUT_WIDTH-1:0];
    end else if (sum_wide[OUT_WIDTH]) begin
      step_sum = ACC_MIN;
    end else begin
      step_sum = ACC_MAX;
    end
  end
`else
  // Plain wrapping add
  assign step_sum = base + din_ext;
`endif

  // Next-state, counter, accumulator and dump decode
  always_comb begin
    state_nxt      = state;
    ctr_nxt        = ctr;
    acc_nxt        = acc;
    dout_nxt       = dout;
    dout_valid_nxt = 1'b0;
`ifdef ACC_SATURATE_EN
    ovf_window_nxt = ovf_window;
    overflow_nxt   = overflow;
`endif
    case (state)
      IDLE: begin
        ctr_nxt = '0;
        if (sync) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        acc_nxt = step_sum;
`ifdef ACC_SATURATE_EN
        // Sticky within a window; the first step of a window starts clean
        ovf_window_nxt = (win_start ? 1'b0 : ovf_window) | step_ovf;
`endif
        if (sync || win_last) begin
          ctr_nxt = '0;
        end else begin
          ctr_nxt = ctr + CTR_WIDTH'(1);
        end
        // A sync mid-window just restarts the count; only the last sample dumps
        if (win_last) begin
          dout_nxt       = step_sum;
          dout_valid_nxt = 1'b1;
`ifdef ACC_SATURATE_EN
          overflow_nxt   = ovf_window_nxt;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        ctr_nxt   = '0;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctr        <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      ctr        <= ctr_nxt;
      acc        <= acc_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
    end
  end

`ifdef ACC_SATURATE_EN
  // Window overflow tracking and its reported copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_window <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ovf_window <= ovf_window_nxt;
      overflow   <= overflow_nxt;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_accumulate_and_dump.sv
// Scoreboard bench for accumulate_and_dump: directed windows push expected
// dumps (value, overflow, strobe cycle); negedge monitors pop and compare.
module tb_accumulate_and_dump;

  typedef struct {
    logic [11:0] d;
    logic        o;
    int          c;
  } exp12_t;

  typedef struct {
    logic [8:0] d;
    logic       o;
    int         c;
  } exp9_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        sync  = 1'b0;
  logic        sync9 = 1'b0;
  logic [7:0]  din   = '0;
  logic [7:0]  din9  = '0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        overflow;
  logic [8:0]  dout9;
  logic        dout_valid9;
  logic        overflow9;

  int cyc_cnt = 0;
  int total   = 0;
  int bad     = 0;

  exp12_t q_main[$];
  exp9_t  q_nine[$];

  accumulate_and_dump #(.IN_WIDTH(8), .OUT_WIDTH(12), .PERIOD(4)) dut (
    .clk(clk), .rst(rst), .sync(sync), .din(din),
    .dout(dout), .dout_valid(dout_valid), .overflow(overflow)
  );

  accumulate_and_dump #(.IN_WIDTH(8), .OUT_WIDTH(9), .PERIOD(4)) dut9 (
    .clk(clk), .rst(rst), .sync(sync9), .din(din9),
    .dout(dout9), .dout_valid(dout_valid9), .overflow(overflow9)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor for the 12-bit instance
  always @(negedge clk) begin
    exp12_t e;
    if (dout_valid) begin
      total++;
      if (q_main.size() == 0) begin
        bad++;
        $display("FAIL main_strobe: unexpected strobe dout=%h ovf=%b cyc=%0d", dout, overflow, cyc_cnt);
      end else begin
        e = q_main.pop_front();
        if (dout !== e.d || overflow !== e.o || cyc_cnt != e.c) begin
          bad++;
          $display("FAIL main_dump: got dout=%h ovf=%b cyc=%0d, want dout=%h ovf=%b cyc=%0d",
                   dout, overflow, cyc_cnt, e.d, e.o, e.c);
        end
      end
    end
  end

  // Monitor for the 9-bit instance
  always @(negedge clk) begin
    exp9_t e;
    if (dout_valid9) begin
      total++;
      if (q_nine.size() == 0) begin
        bad++;
        $display("FAIL nine_strobe: unexpected strobe dout=%h ovf=%b cyc=%0d", dout9, overflow9, cyc_cnt);
      end else begin
        e = q_nine.pop_front();
        if (dout9 !== e.d || overflow9 !== e.o || cyc_cnt != e.c) begin
          bad++;
          $display("FAIL nine_dump: got dout=%h ovf=%b cyc=%0d, want dout=%h ovf=%b cyc=%0d",
                   dout9, overflow9, cyc_cnt, e.d, e.o, e.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock with the main instance driven
  task automatic cyc(input logic s, input logic [7:0] d);
    sync = s;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  // One clock with the 9-bit instance driven
  task automatic cyc9(input logic s, input logic [7:0] d);
    sync9 = s;
    din9  = d;
    @(posedge clk);
    #1;
  endtask

  // Expected dump appears after the next posedge; call just before the last sample
  task automatic push_main(input logic [11:0] d, input logic o);
    q_main.push_back('{d: d, o: o, c: cyc_cnt + 1});
  endtask

  task automatic push_nine(input logic [8:0] d, input logic o);
    q_nine.push_back('{d: d, o: o, c: cyc_cnt + 1});
  endtask

  task automatic do_reset();
    sync  = 1'b0;
    din   = '0;
    sync9 = 1'b0;
    din9  = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [8:0] sat_exp;
    logic       sat_ovf;

    // Reset state of both instances
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dout9", 32'(dout9), 32'd0);
    chk("rst_valid9", 32'(dout_valid9), 32'd0);
    chk("rst_ovf9", 32'(overflow9), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: no sync -> stays idle, no strobes
    repeat (20) cyc(1'b0, 8'd1);
    chk("idle_dout", 32'(dout), 32'd0);

    // 2: two back-to-back windows, 10 then -4
    do_reset();
    cyc(1'b1, 8'd0);
    cyc(1'b0, 8'd1);
    cyc(1'b0, 8'd2);
    cyc(1'b0, 8'd3);
    push_main(12'd10, 1'b0);
    cyc(1'b0, 8'd4);
    repeat (3) cyc(1'b0, 8'hFF);
    push_main(12'hFFC, 1'b0);
    cyc(1'b0, 8'hFF);
    cyc(1'b0, 8'd0);

    // 3: aborted partial window, then a clean window of ones
    do_reset();
    cyc(1'b1, 8'd0);
    cyc(1'b0, 8'd5);
    cyc(1'b0, 8'd5);
    cyc(1'b1, 8'd9);
    repeat (3) cyc(1'b0, 8'd1);
    push_main(12'd4, 1'b0);
    cyc(1'b0, 8'd1);
    cyc(1'b0, 8'd0);

    // 4: sync on the last sample dumps normally; next window starts clean
    do_reset();
    cyc(1'b1, 8'd0);
    cyc(1'b0, 8'd1);
    cyc(1'b0, 8'd2);
    cyc(1'b0, 8'd3);
    push_main(12'd10, 1'b0);
    cyc(1'b1, 8'd4);
    repeat (3) cyc(1'b0, 8'd2);
    push_main(12'd8, 1'b0);
    cyc(1'b0, 8'd2);
    cyc(1'b0, 8'd0);

    // 5: 9-bit accumulator overflow
`ifdef ACC_SATURATE_EN
    sat_exp = 9'd255;
    sat_ovf = 1'b1;
`else
    sat_exp = 9'h1FC;
    sat_ovf = 1'b0;
`endif
    do_reset();
    cyc9(1'b1, 8'd0);
    repeat (3) cyc9(1'b0, 8'd127);
    push_nine(sat_exp, sat_ovf);
    cyc9(1'b0, 8'd127);
    repeat (3) cyc9(1'b0, 8'd0);
    push_nine(9'd0, 1'b0);
    cyc9(1'b0, 8'd0);
    cyc9(1'b0, 8'd0);

    // 6: async reset mid-window after a dump of 10
    do_reset();
    cyc(1'b1, 8'd0);
    cyc(1'b0, 8'd1);
    cyc(1'b0, 8'd2);
    cyc(1'b0, 8'd3);
    push_main(12'd10, 1'b0);
    cyc(1'b0, 8'd4);
    cyc(1'b0, 8'd1);
    cyc(1'b0, 8'd1);
    din = 8'd1;
    rst = 1'b1;
    #1;
    chk("async_dout", 32'(dout), 32'd0);
    chk("async_valid", 32'(dout_valid), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) cyc(1'b0, 8'd3);
    chk("post_rst_dout", 32'(dout), 32'd0);

    // Every expected dump must have been seen
    repeat (2) cyc(1'b0, 8'd0);
    chk("main_queue_left", 32'(q_main.size()), 32'd0);
    chk("nine_queue_left", 32'(q_nine.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
